// File: rtl/led_framebuffer_if.sv
// Write, clear, scan-read and swap signals of led_framebuffer, bundled for the module port.
// The master side drives requests; the slave side (the framebuffer) returns status and pixel data.
interface led_framebuffer_if #(
  parameter int COLS        = 32,
  parameter int ROWS        = 16,
  parameter int COLOR_DEPTH = 1
);
  localparam int COL_BITS     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_BITS     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ADDRESS_BITS = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1;
  localparam int PIX          = 3 * COLOR_DEPTH;

  logic                    i_wr_valid;
  logic                    o_wr_ready;
  logic [COL_BITS-1:0]     i_wr_x;
  logic [ROW_BITS-1:0]     i_wr_y;
  logic [PIX-1:0]          i_wr_rgb;
  logic                    o_wr_drop;
  logic                    i_clear;
  logic                    o_busy;
  logic                    i_rd_en;
  logic [ADDRESS_BITS-1:0] i_rd_addr;
  logic [COL_BITS-1:0]     i_rd_col;
  logic [PIX-1:0]          o_rd_rgb_0;
  logic [PIX-1:0]          o_rd_rgb_1;
  logic                    o_rd_valid;
  logic                    i_swap_req;
  logic                    i_frame_done;
  logic                    o_swap_done;

  modport master (
    output i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_clear,
           i_rd_en, i_rd_addr, i_rd_col, i_swap_req, i_frame_done,
    input  o_wr_ready, o_wr_drop, o_busy, o_rd_rgb_0, o_rd_rgb_1,
           o_rd_valid, o_swap_done
  );

  modport slave (
    input  i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_clear,
           i_rd_en, i_rd_addr, i_rd_col, i_swap_req, i_frame_done,
    output o_wr_ready, o_wr_drop, o_busy, o_rd_rgb_0, o_rd_rgb_1,
           o_rd_valid, o_swap_done
  );
endinterface

// File: rtl/led_framebuffer.sv
// Pixel store for a split-scan LED panel: pixel writes, full-buffer clear sweep, dual-row scan reads.
// Define LED_FRAMEBUFFER_DOUBLE_BUFFER_EN for front/back buffers exchanged at end of frame.
module led_framebuffer #(
  parameter int COLS        = 32,
  parameter int ROWS        = 16,
  parameter int COLOR_DEPTH = 1
) (
  input logic              i_clock,
  input logic              i_reset,
  led_framebuffer_if.slave bus
);
  localparam int PIX    = 3 * COLOR_DEPTH;
  localparam int PIXELS = ROWS * COLS;
  localparam int HALF   = ROWS / 2;
`ifdef LED_FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int DEPTH    = NBUF * PIXELS;
  localparam int MEM_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]          state;
  logic [CNT_BITS-1:0] clr_cnt;
  logic                wr_drop;
  logic                rd_valid;
  logic [PIX-1:0]      rd_rgb_0;
  logic [PIX-1:0]      rd_rgb_1;
  logic                front;
  logic                back;
  logic                swap_done;
  logic [PIX-1:0]      mem [DEPTH];

  logic                wr_ready;
  logic                wr_fire;
  logic                wr_in_range;
  logic                rd_in_range;
  logic [MEM_BITS-1:0] wr_addr;
  logic [MEM_BITS-1:0] clr_addr;
  logic [MEM_BITS-1:0] rd_addr_0;
  logic [MEM_BITS-1:0] rd_addr_1;

  function automatic logic [MEM_BITS-1:0] mem_index(input logic sel, input int row,
                                                    input int col);
    return MEM_BITS'((sel ? PIXELS : 0) + row * COLS + col);
  endfunction

  // A clear request masks any same-cycle write.
  assign wr_ready    = (state == S_IDLE) && !bus.i_clear;
  assign wr_fire     = bus.i_wr_valid && wr_ready;
  assign wr_in_range = (int'(bus.i_wr_x) < COLS) && (int'(bus.i_wr_y) < ROWS);
  assign rd_in_range = (int'(bus.i_rd_addr) < HALF) && (int'(bus.i_rd_col) < COLS);

  assign wr_addr   = mem_index(back, int'(bus.i_wr_y), int'(bus.i_wr_x));
  assign clr_addr  = mem_index(back, 0, int'(clr_cnt));
  assign rd_addr_0 = mem_index(front, int'(bus.i_rd_addr), int'(bus.i_rd_col));
  assign rd_addr_1 = mem_index(front, int'(bus.i_rd_addr) + HALF, int'(bus.i_rd_col));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_fire && !wr_in_range;
      case (state)
        S_IDLE: begin
          if (bus.i_clear) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CNT_BITS'(PIXELS - 1)) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the pixel array has no reset -- a reset sweep would take ROWS*COLS cycles and
  // would stop the array mapping onto block RAM; software clears it with i_clear instead.
  always_ff @(posedge i_clock) begin
    if (state == S_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire && wr_in_range) begin
      mem[wr_addr] <= bus.i_wr_rgb;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_valid <= 1'b0;
      rd_rgb_0 <= '0;
      rd_rgb_1 <= '0;
    end else begin
      rd_valid <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        rd_rgb_0 <= rd_in_range ? mem[rd_addr_0] : '0;
        rd_rgb_1 <= rd_in_range ? mem[rd_addr_1] : '0;
      end
    end
  end

`ifdef LED_FRAMEBUFFER_DOUBLE_BUFFER_EN
  logic pending;

  // A new request in the swap cycle re-arms pending for the next frame.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      front     <= 1'b0;
      pending   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= bus.i_frame_done && pending;
      if (bus.i_frame_done && pending) begin
        front <= ~front;
      end
      if (bus.i_swap_req) begin
        pending <= 1'b1;
      end else if (bus.i_frame_done) begin
        pending <= 1'b0;
      end
    end
  end

  assign back = ~front;
`else
  logic unused_swap;

  assign front       = 1'b0;
  assign back        = 1'b0;
  assign swap_done   = 1'b0;
  assign unused_swap = bus.i_swap_req ^ bus.i_frame_done;
`endif

  assign bus.o_wr_ready  = wr_ready;
  assign bus.o_wr_drop   = wr_drop;
  assign bus.o_busy      = (state == S_CLEAR);
  assign bus.o_rd_valid  = rd_valid;
  assign bus.o_rd_rgb_0  = rd_rgb_0;
  assign bus.o_rd_rgb_1  = rd_rgb_1;
  assign bus.o_swap_done = swap_done;
endmodule

// File: tb/tb_led_framebuffer.sv
// Self-checking bench for led_framebuffer: a 32x16 instance against a frame-array model,
// plus a 32x12 instance for out-of-range row writes.
module tb_led_framebuffer;
`ifdef LED_FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int AC = 32;
  localparam int AR = 16;
  localparam int BR = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_framebuffer_if #(.COLS(AC), .ROWS(AR), .COLOR_DEPTH(1)) bus_a ();
  led_framebuffer_if #(.COLS(AC), .ROWS(BR), .COLOR_DEPTH(1)) bus_b ();

  led_framebuffer #(.COLS(AC), .ROWS(AR), .COLOR_DEPTH(1)) dut_a (
    .i_clock(clk), .i_reset(rst), .bus(bus_a)
  );
  led_framebuffer #(.COLS(AC), .ROWS(BR), .COLOR_DEPTH(1)) dut_b (
    .i_clock(clk), .i_reset(rst), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Model: whole frames indexed [buffer][y][x]; buffer 1 exists only with double buffering.
  logic [2:0] fb_a [2][AR][AC];
  int         front_a;
  bit         pend_a;

  function automatic int wbuf();
    return DB ? 1 - front_a : 0;
  endfunction

  function automatic int rbuf();
    return DB ? front_a : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_a.i_wr_valid = 0; bus_a.i_wr_x = '0; bus_a.i_wr_y = '0; bus_a.i_wr_rgb = '0;
    bus_a.i_clear = 0; bus_a.i_rd_en = 0; bus_a.i_rd_addr = '0; bus_a.i_rd_col = '0;
    bus_a.i_swap_req = 0; bus_a.i_frame_done = 0;
    bus_b.i_wr_valid = 0; bus_b.i_wr_x = '0; bus_b.i_wr_y = '0; bus_b.i_wr_rgb = '0;
    bus_b.i_clear = 0; bus_b.i_rd_en = 0; bus_b.i_rd_addr = '0; bus_b.i_rd_col = '0;
    bus_b.i_swap_req = 0; bus_b.i_frame_done = 0;
  endtask

  // One clock; applies the swap rules to the model and checks the swap pulse.
  task automatic tick_a();
    bit fd, sr, exp_sd;
    fd     = bus_a.i_frame_done;
    sr     = bus_a.i_swap_req;
    exp_sd = DB && fd && pend_a;
    @(posedge clk);
    #1;
    if (exp_sd) front_a = 1 - front_a;
    if (DB) begin
      if (sr) pend_a = 1'b1;
      else if (fd) pend_a = 1'b0;
    end
    check("swap_done", bus_a.o_swap_done, exp_sd);
  endtask

  task automatic write_a(input int x, input int y, input logic [2:0] rgb);
    bus_a.i_wr_valid = 1; bus_a.i_wr_x = 5'(x); bus_a.i_wr_y = 4'(y); bus_a.i_wr_rgb = rgb;
    #1;
    check("wr_ready", bus_a.o_wr_ready, 1);
    fb_a[wbuf()][y][x] = rgb;
    tick_a();
    bus_a.i_wr_valid = 0;
    check("wr_drop_in_range", bus_a.o_wr_drop, 0);
  endtask

  task automatic read_a(input int addr, input int col);
    logic [2:0] e0, e1;
    e0 = fb_a[rbuf()][addr][col];
    e1 = fb_a[rbuf()][addr + AR / 2][col];
    bus_a.i_rd_en = 1; bus_a.i_rd_addr = 3'(addr); bus_a.i_rd_col = 5'(col);
    tick_a();
    bus_a.i_rd_en = 0;
    check("rd_valid", bus_a.o_rd_valid, 1);
    check("rd_rgb_0", bus_a.o_rd_rgb_0, e0);
    check("rd_rgb_1", bus_a.o_rd_rgb_1, e1);
    tick_a();
    check("rd_valid_low", bus_a.o_rd_valid, 0);
    check("rd_hold_0", bus_a.o_rd_rgb_0, e0);
  endtask

  // Launches a clear on both instances; the model's target buffer ends up all zero.
  task automatic start_clear(input bit with_write);
    bus_a.i_clear = 1; bus_b.i_clear = 1;
    if (with_write) begin
      bus_a.i_wr_valid = 1; bus_a.i_wr_x = 5'd1; bus_a.i_wr_y = 4'd1; bus_a.i_wr_rgb = 3'b111;
    end
    #1;
    check("ready_low_on_clear", bus_a.o_wr_ready, 0);
    for (int y = 0; y < AR; y++)
      for (int x = 0; x < AC; x++) fb_a[wbuf()][y][x] = 3'b000;
    tick_a();
    bus_a.i_clear = 0; bus_b.i_clear = 0; bus_a.i_wr_valid = 0;
    check("busy_after_clear_req", bus_a.o_busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_a.o_busy === 1'b1 && n < 2000) begin
      n++;
      tick_a();
    end
    check("clear_finished", bus_a.o_busy, 0);
  endtask

  task automatic init_all();
    start_clear(1'b0);
    wait_idle();
    if (DB) begin
      bus_a.i_swap_req = 1; bus_b.i_swap_req = 1;
      tick_a();
      bus_a.i_swap_req = 0; bus_b.i_swap_req = 0;
      bus_a.i_frame_done = 1; bus_b.i_frame_done = 1;
      tick_a();
      bus_a.i_frame_done = 0; bus_b.i_frame_done = 0;
      tick_a();
      start_clear(1'b0);
      wait_idle();
    end
  endtask

  initial begin
    int n;
    int x, y, op;
    logic [2:0] e0, e1, saved, rgb;

    idle_inputs();
    front_a = 0;
    pend_a  = 1'b0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus_a.o_busy, 0);
    check("rst_rd_valid", bus_a.o_rd_valid, 0);
    check("rst_rgb_0", bus_a.o_rd_rgb_0, 0);
    check("rst_rgb_1", bus_a.o_rd_rgb_1, 0);
    check("rst_drop", bus_a.o_wr_drop, 0);
    check("rst_swap_done", bus_a.o_swap_done, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus_a.o_wr_ready, 1);

    init_all();

    // Basic write/read, both half-panel rows.
    write_a(5, 3, 3'b010);
    read_a(3, 5);
    write_a(31, 12, 3'b111);
    read_a(4, 31);

    // Clear with a competing write, a read and an ignored clear during the sweep.
    write_a(0, 0, 3'b101);
    write_a(0, 8, 3'b110);
    saved = fb_a[rbuf()][8][0];
    start_clear(1'b1);
    n = 1;
    while (bus_a.o_busy === 1'b1 && n < 2000) begin
      if (n == 20) begin
        bus_a.i_rd_en = 1; bus_a.i_rd_addr = '0; bus_a.i_rd_col = '0;
        e0 = fb_a[rbuf()][0][0];
        e1 = saved;
      end
      if (n == 21) begin
        bus_a.i_rd_en = 0;
        check("rd_valid_mid_clear", bus_a.o_rd_valid, 1);
        check("rd_rgb_0_mid_clear", bus_a.o_rd_rgb_0, e0);
        check("rd_rgb_1_mid_clear", bus_a.o_rd_rgb_1, e1);
      end
      if (n == 40) bus_a.i_clear = 1;
      if (n == 41) bus_a.i_clear = 0;
      tick_a();
      if (bus_a.o_busy === 1'b1) n++;
    end
    check("clear_cycles", 32'(n), 32'(AR * AC));
    check("ready_after_clear", bus_a.o_wr_ready, 1);
    for (int a = 0; a < AR / 2; a++)
      for (int c = 0; c < AC; c++) read_a(a, c);

    // Out-of-range row on the 12-row instance.
    bus_b.i_wr_valid = 1; bus_b.i_wr_x = 5'd4; bus_b.i_wr_y = 4'd13; bus_b.i_wr_rgb = 3'b111;
    #1;
    check("b_ready", bus_b.o_wr_ready, 1);
    tick_a();
    bus_b.i_wr_y = 4'd11; bus_b.i_wr_rgb = 3'b110;
    check("b_drop_pulse", bus_b.o_wr_drop, 1);
    tick_a();
    bus_b.i_wr_valid = 0;
    check("b_drop_in_range", bus_b.o_wr_drop, 0);
    bus_b.i_rd_en = 1; bus_b.i_rd_addr = 3'd5; bus_b.i_rd_col = 5'd4;
    tick_a();
    check("b_drop_end", bus_b.o_wr_drop, 0);
    check("b_rd_valid", bus_b.o_rd_valid, 1);
    check("b_row5", bus_b.o_rd_rgb_0, 0);
    check("b_row11", bus_b.o_rd_rgb_1, DB ? 3'b000 : 3'b110);
    bus_b.i_rd_addr = 3'd1;
    tick_a();
    bus_b.i_rd_en = 0;
    check("b_row1", bus_b.o_rd_rgb_0, 0);
    check("b_row7", bus_b.o_rd_rgb_1, 0);

    // Buffer swap, then a swap coinciding with a fresh request.
    write_a(7, 2, 3'b101);
    read_a(2, 7);
    bus_a.i_swap_req = 1;
    tick_a();
    bus_a.i_swap_req = 0;
    read_a(2, 7);
    repeat (3) tick_a();
    bus_a.i_frame_done = 1;
    tick_a();
    bus_a.i_frame_done = 0;
    tick_a();
    read_a(2, 7);
    bus_a.i_swap_req = 1;
    tick_a();
    bus_a.i_frame_done = 1;
    tick_a();
    bus_a.i_swap_req = 0;
    tick_a();
    bus_a.i_frame_done = 0;
    tick_a();
    read_a(2, 7);

    // Randomised traffic against the frame model.
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 9));
      x  = int'($urandom_range(0, AC - 1));
      y  = int'($urandom_range(0, AR - 1));
      rgb = 3'($urandom);
      if (op < 4) begin
        write_a(x, y, rgb);
        read_a(y % (AR / 2), x);
      end else if (op < 8) begin
        read_a(y % (AR / 2), x);
      end else if (op == 8) begin
        bus_a.i_swap_req = 1;
        tick_a();
        bus_a.i_swap_req = 0;
      end else begin
        bus_a.i_frame_done = 1;
        tick_a();
        bus_a.i_frame_done = 0;
      end
    end

    // Reset in the middle of a clear sweep.
    start_clear(1'b0);
    repeat (99) tick_a();
    rst = 1'b1;
    #1;
    check("midclr_rst_busy", bus_a.o_busy, 0);
    check("midclr_rst_rd_valid", bus_a.o_rd_valid, 0);
    check("midclr_rst_rgb_0", bus_a.o_rd_rgb_0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    front_a = 0;
    pend_a  = 1'b0;
    #1;
    check("midclr_ready", bus_a.o_wr_ready, 1);
    check("midclr_busy", bus_a.o_busy, 0);
    init_all();
    for (int i = 0; i < 8; i++) read_a(int'($urandom_range(0, AR / 2 - 1)),
                                       int'($urandom_range(0, AC - 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
